// File: rtl/wb_arb2_ctrl.sv
// Two-master Wishbone round-robin arbiter onto one shared slave port.
// Optional ack timeout with error strobe: define WB_ARB2_TIMEOUT_EN.
module wb_arb2_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic [DW-1:0]     m1_dat_o,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m0_we_i,
  input  logic              m1_we_i,
  input  logic              m0_stb_i,
  input  logic              m1_stb_i,
  output logic              m0_ack_o,
  output logic              m1_ack_o,
  output logic              m0_err_o,
  output logic              m1_err_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_stb_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

`ifdef WB_ARB2_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
`else
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  state_t state;
  logic   last_gnt;   // 1 = master 1 was served last
  logic   cur;
  logic   cur_stb;
  logic   g0;
  logic   g1;

  assign cur     = (state == GNT1);
  assign cur_stb = cur ? m1_stb_i : m0_stb_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
`ifdef WB_ARB2_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef WB_ARB2_TIMEOUT_EN
          cnt <= '0;
`endif
          if (m0_stb_i && (!m1_stb_i || last_gnt)) state <= GNT0;
          else if (m1_stb_i)                        state <= GNT1;
        end
        GNT0, GNT1: begin
          // an abandoned request does not count as service for round-robin
          if (!cur_stb) begin
            state <= IDLE;
          end else if (s_ack_i) begin
            last_gnt <= cur;
            state    <= IDLE;
          end
`ifdef WB_ARB2_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            last_gnt <= cur;
            state    <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
`ifdef WB_ARB2_TIMEOUT_EN
        ERR:     state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // outputs are held quiet for as long as reset is applied
  assign g0    = !rst_i && (state == GNT0);
  assign g1    = !rst_i && (state == GNT1);
  assign gnt_o = {g1, g0};

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (g0) begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_we_o   = m0_we_i;
      s_stb_o  = m0_stb_i;
      m0_ack_o = s_ack_i;
      m0_dat_o = s_dat_i;
    end else if (g1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      s_stb_o  = m1_stb_i;
      m1_ack_o = s_ack_i;
      m1_dat_o = s_dat_i;
    end
  end

`ifdef WB_ARB2_TIMEOUT_EN
  // last_gnt already names the timed-out master while in ERR
  assign m0_err_o = !rst_i && (state == ERR) && !last_gnt;
  assign m1_err_o = !rst_i && (state == ERR) &&  last_gnt;
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: doc/wb_arb2_ctrl.md
WB_ARB2_CTRL -- requirements
Module: wb_arb2_ctrl

Interface
REQ-001 Parameter DW, default 32, data bus width.
REQ-002 Parameter AW, default 32, address bus width.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles a granted transfer waits for s_ack_i (legal range 1..255).
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 m0_dat_i / m1_dat_i  in  DW  write data from master 0 / 1.
REQ-007 m0_dat_o / m1_dat_o  out  DW  read data returned to master 0 / 1.
REQ-008 m0_adr_i / m1_adr_i  in  AW  address from master 0 / 1.
REQ-009 m0_sel_i / m1_sel_i  in  DW/8  byte selects from master 0 / 1.
REQ-010 m0_we_i / m1_we_i  in  1  write enable from master 0 / 1.
REQ-011 m0_stb_i / m1_stb_i  in  1  transfer request from master 0 / 1.
REQ-012 m0_ack_o / m1_ack_o  out  1  transfer-complete strobe to master 0 / 1.
REQ-013 m0_err_o / m1_err_o  out  1  timeout-error strobe to master 0 / 1.
REQ-014 s_dat_o, s_adr_o, s_sel_o, s_we_o, s_stb_o  out  DW, AW, DW/8, 1, 1  shared slave-side bus toward the interconnect.
REQ-015 s_dat_i  in  DW  read data from the shared slave side.
REQ-016 s_ack_i  in  1  acknowledge from the shared slave side.
REQ-017 gnt_o  out  2  one-hot current grant: bit0 = master 0, bit1 = master 1, 00 = idle.

Function
REQ-018 The FSM SHALL have states IDLE, GNT0, GNT1 and ERR.
REQ-019 In IDLE with only mX_stb_i high, the FSM SHALL enter GNTX at the next edge, giving one cycle of arbitration latency.
REQ-020 In IDLE with both strobes high, the FSM SHALL grant the master not served last (round-robin) using a last_gnt register.
REQ-021 In GNTX, s_adr_o, s_dat_o, s_sel_o, s_we_o and s_stb_o SHALL combinationally follow master X.
REQ-022 In GNTX, mX_ack_o SHALL equal s_ack_i and mX_dat_o SHALL equal s_dat_i.
REQ-023 The non-granted master SHALL see ack_o = 0, err_o = 0 and dat_o = 0.
REQ-024 On s_ack_i in GNTX, the FSM SHALL update last_gnt to X and return to IDLE, so each grant covers exactly one transfer.
REQ-025 If mX_stb_i drops in GNTX before s_ack_i, the FSM SHALL return to IDLE at the next edge with no ack and without updating last_gnt.
REQ-026 In IDLE and ERR, all s_* outputs SHALL be 0 and gnt_o SHALL be 00.
REQ-027 A request arriving while the other master is granted SHALL wait; it is serviced in the IDLE cycle that follows.
REQ-028 s_ack_i received in IDLE or ERR SHALL be ignored.

Reset
REQ-029 When rst_i is high at a clock edge, the block SHALL load state = IDLE, last_gnt = master 1 (so master 0 wins the first contention), and timeout counter = 0.
REQ-030 While in reset, all outputs SHALL be 0.
REQ-031 A reset asserted mid-transfer SHALL abort the transfer at that edge with no ack or err.

Configuration
REQ-032 With macro WB_ARB2_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to GNTX and increment each GNTX cycle without s_ack_i.
REQ-033 With WB_ARB2_TIMEOUT_EN defined and the counter equal to TIMEOUT-1 with no ack, the FSM SHALL enter ERR.
REQ-034 In ERR, mX_err_o SHALL be 1 for exactly one cycle, s_stb_o SHALL be 0, last_gnt SHALL be set to X, and the next state SHALL be IDLE.
REQ-035 With WB_ARB2_TIMEOUT_EN undefined, the counter and the ERR state SHALL be absent, m0_err_o and m1_err_o SHALL be tied to 0, and a grant waits on s_ack_i indefinitely.

Verification
REQ-036 Stimulus: after reset, m0 and m1 raise stb in the same cycle, and the slave acks each transfer 2 cycles after stb. Required: gnt_o = 01 first, then 10, alternating thereafter.
REQ-037 Stimulus: m1 writes adr=0xFFFFFF00, dat=0x000000AA, sel=0xF. Required: the s_* outputs carry exactly these values while gnt_o = 10, m1_ack_o pulses once, and m0_ack_o stays 0.
REQ-038 Stimulus: m0 reads with s_dat_i = 0x12345678 and ack. Required: m0_dat_o = 0x12345678 in the ack cycle, and m1_dat_o = 0.
REQ-039 Stimulus: WB_ARB2_TIMEOUT_EN defined, TIMEOUT = 4, and the slave never acks m0. Required: m0_err_o pulses for one cycle, 4 cycles after grant, then IDLE, and a pending m1 request is granted next.
REQ-040 Stimulus: rst_i is asserted while in GNT1 with the slave stalled. Required: at the next edge, gnt_o = 00, s_stb_o = 0, and no ack or err is seen.
REQ-041 Stimulus: m0 drops stb in GNT0 before any ack. Required: IDLE at the next edge, and a simultaneous m1 request is granted one cycle later.
